// File: rtl/key_voice_select.sv
// key_voice_select: debounces eight piano push-buttons, picks one note with
// last-pressed-wins priority (falling back to the lowest still-held key when
// the playing key is released), and routes that note's tone square wave to a
// registered speaker pin.
module key_voice_select #(
  parameter int NUM_KEYS = 8,
  parameter int DEBOUNCE = 250000,
  parameter int CNT_W    = 18,
  parameter int IDX_W    = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic [NUM_KEYS-1:0] tones,
  output logic                speaker,
  output logic                active,
  output logic [IDX_W-1:0]    note_index
);

  typedef enum logic {IDLE, PLAYING} state_t;

  logic [NUM_KEYS-1:0] sync1;
  logic [NUM_KEYS-1:0] sync2;
  logic [NUM_KEYS-1:0] st;
  logic [NUM_KEYS-1:0] st_prev;
  logic [NUM_KEYS-1:0] press;
  logic [NUM_KEYS-1:0] rel;
  logic [CNT_W-1:0]    cnt [NUM_KEYS];

  state_t              state;
  state_t              state_nxt;
  logic [IDX_W-1:0]    idx_nxt;
  logic [IDX_W-1:0]    hi_press;
  logic [IDX_W-1:0]    lo_held;

  // Two-flop synchronizer bringing the raw buttons into the clk domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= keys;
      sync2 <= sync1;
    end
  end

  // Per-key debounce: accept a change only after DEBOUNCE consecutive cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st <= '0;
      for (int unsigned i = 0; i < NUM_KEYS; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        if (sync2[i] == st[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_W'(DEBOUNCE - 1)) begin
          st[i]  <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Previous debounced state for press/release edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) st_prev <= '0;
    else       st_prev <= st;
  end

  // Press/release edges and the two priority encoders used for selection.
  always_comb begin
    press    = st & ~st_prev;
    rel      = ~st & st_prev;
    hi_press = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++)
      if (press[i]) hi_press = IDX_W'(i);
    lo_held = '0;
    for (int unsigned i = NUM_KEYS; i > 0; i--)
      if (st[i-1]) lo_held = IDX_W'(i - 1);
  end

  // Next selection: a new press beats everything, then release of the
  // playing key falls back to the lowest held key or goes idle.
  always_comb begin
    state_nxt = state;
    idx_nxt   = note_index;
    if (|press) begin
      state_nxt = PLAYING;
      idx_nxt   = hi_press;
    end else if (state == PLAYING && rel[note_index]) begin
      if (|st) idx_nxt   = lo_held;
      else     state_nxt = IDLE;
    end
  end

  // FSM and registered outputs; speaker uses the next selection so a
  // change of note takes effect in the same cycle as the index update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      note_index <= '0;
      active     <= 1'b0;
      speaker    <= 1'b0;
    end else begin
      state      <= state_nxt;
      note_index <= idx_nxt;
      active     <= (state_nxt == PLAYING);
      speaker    <= (state_nxt == PLAYING) ? tones[idx_nxt] : 1'b0;
    end
  end

endmodule
